// File: rtl/riscv_run_ctrl.sv
// Boot/run sequencer: streams a program image into imem, releases the core
// from reset, counts run cycles and stops on halt or timeout.
module riscv_run_ctrl #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned CYC_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 300
) (
    input  logic              clk,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              go,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    input  logic              cpu_halt,
    output logic              done,
    output logic              timeout,
    output logic              load_err,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [ADDR_W:0]   words_loaded
);

    // S_FLUSH is the cycle in which the final image word is written to imem.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_idx;
    logic [31:0] byte_buf;

    logic        xfer;
    logic        fresh;
    logic [1:0]  idx_cur;
    logic [31:0] buf_cur;
    logic [ADDR_W:0] wl_cur;
    logic [31:0] word_asm;
    logic        word_done;
    logic        overflow;
    logic        at_limit;

    // A transfer in IDLE/DONE starts a new image, so it sees cleared load state.
    assign xfer      = ld_valid & ld_ready;
    assign fresh     = (state == S_IDLE) || (state == S_DONE);
    assign idx_cur   = fresh ? 2'd0 : byte_idx;
    assign buf_cur   = fresh ? '0 : byte_buf;
    assign wl_cur    = fresh ? '0 : words_loaded;
    assign word_asm  = buf_cur | (32'(ld_data) << {idx_cur, 3'b000});
    assign word_done = xfer & ((idx_cur == 2'd3) | ld_last);
    assign overflow  = (wl_cur == DEPTH);
    assign at_limit  = (cycle_count == CYC_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    state_next = ld_last ? S_FLUSH : S_LOAD;
                end else if (go && (words_loaded != '0)) begin
                    state_next = S_RUN;
                end
            end
            S_LOAD: begin
                if (xfer && ld_last) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: state_next = S_RUN;
            S_RUN: begin
                if (cpu_halt || at_limit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (xfer) begin
                    state_next = ld_last ? S_FLUSH : S_LOAD;
                end else if (go) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ld_ready = 1'b0;
        case (state)
            S_IDLE, S_LOAD, S_DONE: ld_ready = 1'b1;
            default:                ld_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            byte_idx     <= '0;
            byte_buf     <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_rst_n    <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            load_err     <= 1'b0;
            cycle_count  <= '0;
            words_loaded <= '0;
        end else begin
            imem_we   <= 1'b0;
            cpu_rst_n <= (state_next == S_RUN);

            if (xfer) begin
                if (fresh) begin
                    load_err <= 1'b0;
                    done     <= 1'b0;
                    timeout  <= 1'b0;
                end
                if (word_done) begin
                    byte_idx <= '0;
                    byte_buf <= '0;
                    if (overflow) begin
                        load_err     <= 1'b1;
                        words_loaded <= wl_cur;
                    end else begin
                        imem_we      <= 1'b1;
                        imem_addr    <= wl_cur[ADDR_W-1:0];
                        imem_wdata   <= word_asm;
                        words_loaded <= wl_cur + 1'b1;
                    end
                end else begin
                    byte_idx     <= idx_cur + 2'd1;
                    byte_buf     <= word_asm;
                    words_loaded <= wl_cur;
                end
            end

            if ((state != S_RUN) && (state_next == S_RUN)) begin
                cycle_count <= '0;
                done        <= 1'b0;
                timeout     <= 1'b0;
            end

            // The count is frozen on the exiting cycle; halt takes priority.
            if (state == S_RUN) begin
                if (cpu_halt) begin
                    done <= 1'b1;
                end else if (at_limit) begin
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end else begin
                    cycle_count <= cycle_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed bench for riscv_run_ctrl: default instance plus a 4-word imem
// instance for the overflow case.
module tb_riscv_run_ctrl;

    logic        clk = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_last = 1'b0;
    logic        go = 1'b0;
    logic        cpu_halt = 1'b0;

    logic        ld_ready, imem_we, cpu_rst_n, done, timeout, load_err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] cycle_count;
    logic [8:0]  words_loaded;

    logic        s_ld_ready, s_imem_we, s_cpu_rst_n, s_done, s_timeout, s_load_err;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic [31:0] s_cycle_count;
    logic [2:0]  s_words_loaded;

    int checks = 0;
    int errors = 0;

    riscv_run_ctrl u_dut (
        .clk(clk), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .go(go), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n),
        .cpu_halt(cpu_halt), .done(done), .timeout(timeout), .load_err(load_err),
        .cycle_count(cycle_count), .words_loaded(words_loaded)
    );

    riscv_run_ctrl #(.ADDR_W(2)) u_small (
        .clk(clk), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(s_ld_ready), .go(go), .imem_we(s_imem_we),
        .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .cpu_rst_n(s_cpu_rst_n),
        .cpu_halt(cpu_halt), .done(s_done), .timeout(s_timeout), .load_err(s_load_err),
        .cycle_count(s_cycle_count), .words_loaded(s_words_loaded)
    );

    always #5 clk = ~clk;

    int          log_n = 0;
    logic [7:0]  log_addr [64];
    logic [31:0] log_data [64];
    int          s_log_n = 0;
    logic [1:0]  s_log_addr [64];
    logic [31:0] s_log_data [64];

    always @(negedge clk) begin
        if (imem_we && log_n < 64) begin
            log_addr[log_n] = imem_addr;
            log_data[log_n] = imem_wdata;
            log_n++;
        end
        if (s_imem_we && s_log_n < 64) begin
            s_log_addr[s_log_n] = s_imem_addr;
            s_log_data[s_log_n] = s_imem_wdata;
            s_log_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where cycle_count == target.
    task automatic run_until_count(input logic [31:0] target);
        for (int i = 0; i < 400 && cycle_count != target; i++) @(negedge clk);
        check("reach_count", cycle_count, target);
    endtask

    task automatic halt_now();
        cpu_halt = 1'b1;
        @(posedge clk);
        #1;
        cpu_halt = 1'b0;
        @(negedge clk);
    endtask

    int base;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        check("rst_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_ready", 32'(ld_ready), 32'd1);
        @(posedge clk); #1; start = 1'b1;

        // go with an empty image is ignored
        go = 1'b1; @(posedge clk); #1; go = 1'b0;
        @(negedge clk);
        check("go_empty_rst_n", 32'(cpu_rst_n), 32'd0);
        check("go_empty_ready", 32'(ld_ready), 32'd1);

        // Test 1: two full words
        @(posedge clk); #1;
        base = log_n;
        send(8'h13, 1'b0); send(8'h05, 1'b0); send(8'hA0, 1'b0); send(8'h00, 1'b0);
        send(8'h93, 1'b0); send(8'h05, 1'b0); send(8'hB0, 1'b0); send(8'h00, 1'b1);
        @(negedge clk);
        check("t1_flush_ready", 32'(ld_ready), 32'd0);
        check("t1_flush_rst_n", 32'(cpu_rst_n), 32'd0);
        @(negedge clk);
        check("t1_nwrites", 32'(log_n - base), 32'd2);
        check("t1_addr0", 32'(log_addr[base]), 32'd0);
        check("t1_data0", log_data[base], 32'h00A00513);
        check("t1_addr1", 32'(log_addr[base+1]), 32'd1);
        check("t1_data1", log_data[base+1], 32'h00B00593);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_run_rst_n", 32'(cpu_rst_n), 32'd1);
        check("t1_run_count", cycle_count, 32'd0);

        // Test 3: halt on RUN cycle 20, then rerun
        run_until_count(32'd20);
        halt_now();
        check("t3_done", 32'(done), 32'd1);
        check("t3_timeout", 32'(timeout), 32'd0);
        check("t3_count", cycle_count, 32'd20);
        check("t3_rst_n", 32'(cpu_rst_n), 32'd0);
        @(negedge clk);
        check("t3_hold_count", cycle_count, 32'd20);
        go = 1'b1; @(posedge clk); #1; go = 1'b0;
        @(negedge clk);
        check("t3_go_count", cycle_count, 32'd0);
        check("t3_go_done", 32'(done), 32'd0);
        check("t3_go_rst_n", 32'(cpu_rst_n), 32'd1);
        @(negedge clk);
        check("t3_go_count1", cycle_count, 32'd1);

        // Test 4a: timeout
        run_until_count(32'd299);
        @(negedge clk);
        check("t4_done", 32'(done), 32'd1);
        check("t4_timeout", 32'(timeout), 32'd1);
        check("t4_count", cycle_count, 32'd299);
        check("t4_rst_n", 32'(cpu_rst_n), 32'd0);

        // Test 2: fresh load from DONE with partial last word
        @(posedge clk); #1;
        base = log_n;
        send(8'h11, 1'b0);
        check("t2_clr_timeout", 32'(timeout), 32'd0);
        check("t2_clr_done", 32'(done), 32'd0);
        send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0); send(8'h55, 1'b1);
        @(negedge clk); @(negedge clk);
        check("t2_nwrites", 32'(log_n - base), 32'd2);
        check("t2_addr0", 32'(log_addr[base]), 32'd0);
        check("t2_data0", log_data[base], 32'h44332211);
        check("t2_addr1", 32'(log_addr[base+1]), 32'd1);
        check("t2_data1", log_data[base+1], 32'h00000055);
        check("t2_words", 32'(words_loaded), 32'd2);

        // Test 4b: halt on the timeout cycle wins
        run_until_count(32'd299);
        halt_now();
        check("t4b_done", 32'(done), 32'd1);
        check("t4b_timeout", 32'(timeout), 32'd0);
        check("t4b_count", cycle_count, 32'd299);

        // go and transfer together in DONE: transfer wins
        @(posedge clk); #1;
        base = log_n;
        go = 1'b1;
        send(8'hAA, 1'b0);
        go = 1'b0;
        @(negedge clk);
        check("gx_ready", 32'(ld_ready), 32'd1);
        check("gx_rst_n", 32'(cpu_rst_n), 32'd0);
        check("gx_words", 32'(words_loaded), 32'd0);
        @(posedge clk); #1;
        send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0); send(8'hEE, 1'b1);
        @(negedge clk); @(negedge clk);
        check("gx_nwrites", 32'(log_n - base), 32'd2);
        check("gx_data0", log_data[base], 32'hDDCCBBAA);
        check("gx_data1", log_data[base+1], 32'h000000EE);

        // Test 6: async reset mid-RUN
        run_until_count(32'd7);
        #2;
        start = 1'b0;
        #1;
        check("t6_rst_n", 32'(cpu_rst_n), 32'd0);
        check("t6_count", cycle_count, 32'd0);
        check("t6_words", 32'(words_loaded), 32'd0);
        check("t6_ready", 32'(ld_ready), 32'd1);
        @(posedge clk); #1; start = 1'b1;
        go = 1'b1; @(posedge clk); #1; go = 1'b0;
        @(negedge clk);
        check("t6_go_rst_n", 32'(cpu_rst_n), 32'd0);
        check("t6_go_ready", 32'(ld_ready), 32'd1);

        // Test 5: overflow on the 4-word instance
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        base = s_log_n;
        for (int i = 0; i < 24; i++) send(8'(i), i == 23);
        @(negedge clk); @(negedge clk);
        check("t5_nwrites", 32'(s_log_n - base), 32'd4);
        check("t5_addr0", 32'(s_log_addr[base]), 32'd0);
        check("t5_data0", s_log_data[base], 32'h03020100);
        check("t5_addr3", 32'(s_log_addr[base+3]), 32'd3);
        check("t5_data3", s_log_data[base+3], 32'h0F0E0D0C);
        check("t5_load_err", 32'(s_load_err), 32'd1);
        check("t5_words", 32'(s_words_loaded), 32'd4);
        check("t5_big_words", 32'(words_loaded), 32'd6);
        check("t5_big_err", 32'(load_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
